// File: rtl/alu_result_queue.sv
// ALU output selector with N/Z/C/V flag generation, feeding a DEPTH-entry
// valid/ready result FIFO toward writeback. Also keeps a sticky overflow and an op counter.
module alu_result_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic [1:0]       Control,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] ADD_SUB_In,
  input  logic             Carry_In,
  input  logic             Overflow_In,
  input  logic [WIDTH-1:0] OR_In,
  input  logic [WIDTH-1:0] AND_In,
  output logic             ADD_SUB_SEL,
  output logic [WIDTH-1:0] nBitOut,
  output logic [3:0]       Flags,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic             Sticky_V,
  input  logic             Clear_Sticky,
  output logic [CNT_W-1:0] Op_Count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_OCC = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_data_mem [DEPTH];
  logic [3:0]       r_flag_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_occ;
  logic [CNT_W-1:0] r_op_cnt;
  logic             r_sticky;

  logic [WIDTH-1:0] w_result;
  logic [3:0]       w_flags;
  logic             w_push;
  logic             w_pop;

  // Carry and overflow only mean something for adder results.
  function automatic logic [3:0] calc_flags(input logic [WIDTH-1:0] res,
                                            input logic arith,
                                            input logic carry,
                                            input logic ovf);
    return {res[WIDTH-1], (res == '0), arith & carry, arith & ovf};
  endfunction

  assign ADD_SUB_SEL = (Control == 2'b11);

  always_comb begin
    w_result = AND_In;
    if (Control[1])      w_result = ADD_SUB_In;
    else if (Control[0]) w_result = OR_In;
  end

  assign w_flags = calc_flags(w_result, Control[1], Carry_In, Overflow_In);

  // Full check uses registered occupancy only, so Out_Ready never reaches In_Ready.
  assign In_Ready  = (r_occ != FULL_OCC) && nReset;
  assign Out_Valid = (r_occ != '0);
  assign w_push    = In_Valid && In_Ready;
  assign w_pop     = Out_Valid && Out_Ready;

  assign nBitOut  = Out_Valid ? r_data_mem[r_rd_ptr] : '0;
  assign Flags    = Out_Valid ? r_flag_mem[r_rd_ptr] : '0;
  assign Sticky_V = r_sticky;
  assign Op_Count = r_op_cnt;

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_op_cnt <= '0;
      r_sticky <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_op_cnt <= r_op_cnt + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
      if (w_push && w_flags[0]) r_sticky <= 1'b1;
      else if (Clear_Sticky)    r_sticky <= 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_data_mem[r_wr_ptr] <= w_result;
      r_flag_mem[r_wr_ptr] <= w_flags;
    end
  end

endmodule

// File: doc/alu_result_queue.md
# alu_result_queue

Parametrised successor to the ALU output selector. Selects the AND, OR or add/subtract result per operation, drives the adder's subtract select, and computes N/Z/C/V status flags. Registers each accepted result with its flags into a DEPTH-entry output FIFO using valid/ready handshakes. Sits between the ALU datapath (adder, OR and AND arrays) and the writeback stage.

## Interface
- WIDTH, 16, datapath width in bits (≥2)
- DEPTH, 4, output FIFO entries (power of two, ≥2)
- CNT_W, 16, width of accepted-operation counter
- Clk  input  1  rising-edge clock
- nReset  input  1  synchronous, active-low reset
- Control  input  2  00 AND, 01 OR, 10 ADD, 11 SUB
- In_Valid  input  1  operation presented this cycle
- In_Ready  output  1  queue can accept an operation
- ADD_SUB_In  input  WIDTH  adder/subtractor result
- Carry_In  input  1  adder carry-out
- Overflow_In  input  1  adder signed overflow
- OR_In  input  WIDTH  OR array result
- AND_In  input  WIDTH  AND array result
- ADD_SUB_SEL  output  1  subtract select to adder: Control==11, purely combinational
- nBitOut  output  WIDTH  head-of-queue result
- Flags  output  4  head-of-queue {N,Z,C,V}
- Out_Valid  output  1  head entry valid
- Out_Ready  input  1  consumer takes head entry
- Sticky_V  output  1  set by any accepted op with V=1
- Clear_Sticky  input  1  clears Sticky_V
- Op_Count  output  CNT_W  number of accepted operations, wraps

## Operation
- Result select: Control[1]=1 gives ADD_SUB_In; 00 gives AND_In; 01 gives OR_In.
- Flags per entry:
  - N = result[WIDTH-1].
  - Z = (result == 0).
  - C = Carry_In when Control[1]=1, else 0.
  - V = Overflow_In when Control[1]=1, else 0.
- Push: In_Valid && In_Ready. Writes {result, flags} at the write pointer, increments it and occupancy, and increments Op_Count (modulo 2^CNT_W).
- Pop: Out_Valid && Out_Ready. Increments the read pointer and decrements occupancy.
- Simultaneous push and pop: both occur and occupancy is unchanged.
- Pointers wrap modulo DEPTH. Occupancy ranges 0..DEPTH.
- In_Ready = (occupancy != DEPTH) && nReset.
  - When full, In_Ready is low even if a pop occurs in the same cycle. There is no combinational path from Out_Ready to In_Ready.
- Out_Valid = (occupancy != 0).
- nBitOut and Flags show the head entry when Out_Valid=1 and are forced to 0 when empty.
- Sticky_V:
  - Next value is 1 on a push with V=1.
  - Otherwise it is 0 when Clear_Sticky=1.
  - Otherwise it holds.
  - On a simultaneous set and clear, set wins.
- Inputs sampled while In_Ready=0 are ignored, with no state change.
- ADD_SUB_SEL is independent of the handshake and valid in every cycle, including reset.

## Timing
- All state updates on the rising edge of Clk.
- Reset (nReset=0 at an edge):
  - Pointers, occupancy, Op_Count and Sticky_V go to 0.
  - Out_Valid=0, nBitOut=0, Flags=0.
  - In_Ready=0 while nReset is low and 1 in the first cycle after release.
  - Reset mid-operation discards all queued entries; no pop is reported.
- Latency: an op pushed at edge k appears at the head (Out_Valid=1) after edge k when the queue was empty.
- Throughput: one push and one pop per cycle sustained whenever occupancy is between 1 and DEPTH-1.
- Full: after DEPTH pushes with no pops, In_Ready=0 from the next cycle. It returns to 1 the cycle after the first pop.
- Empty: a pop attempt with Out_Valid=0 has no effect.
- Op_Count wraps from 2^CNT_W-1 to 0 without side effects.

## Test plan
- Reset, then Control=00, AND_In=16'h00F0, one push.
  - Next cycle: Out_Valid=1, nBitOut=16'h00F0, Flags=0000, Op_Count=1, ADD_SUB_SEL=0.
- Control=11, ADD_SUB_In=16'h8000, Carry_In=0, Overflow_In=1, pushed.
  - Required: ADD_SUB_SEL=1 combinationally, Flags=1001, Sticky_V=1 next cycle.
  - A later Clear_Sticky with no V push gives Sticky_V=0.
- Out_Ready=0 and 5 pushes with DEPTH=4 (OR_In values 1,2,3,4,5).
  - Required: In_Ready=0 after the 4th, the 5th ignored, Op_Count=4.
  - Draining gives 1,2,3,4 in order, then Out_Valid=0 and nBitOut=0.
- Continuous In_Valid=1 and Out_Ready=1 for 20 ops with Control=01, OR_In=i.
  - Required: one result per cycle, values 0..19 in order, occupancy stays at 1.
- Control=10, ADD_SUB_In=0, Carry_In=1 gives Flags=0110.
  - Then 2 ops queued, nReset=0 for one edge: Out_Valid=0, Op_Count=0, In_Ready=0 during reset, 1 after.
- With CNT_W=4, 17 pushes with continuous draining gives Op_Count=1.
